// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the core and dmem_responder.
// Signals:
//   ReqValidM  core -> mem  load or store request present in M
//   MemWriteM  core -> mem  1 = store, 0 = load
//   funct3M    core -> mem  access size / sign (b, h, w, bu, hu)
//   ALUResultM core -> mem  byte address
//   WriteDataM core -> mem  right-aligned store data
//   ReadDataM  mem -> core  registered, extended load data
//   StallM     mem -> core  freeze request while the access is in flight
//   ErrM       mem -> core  one-cycle pulse for a rejected request
interface dmem_responder_if;
  logic        ReqValidM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        ErrM;

  modport master (
    output ReqValidM, MemWriteM, funct3M, ALUResultM, WriteDataM,
    input  ReadDataM, StallM, ErrM
  );

  modport slave (
    input  ReqValidM, MemWriteM, funct3M, ALUResultM, WriteDataM,
    output ReadDataM, StallM, ErrM
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage. Accepts a load or store, burns
// WAIT_CYCLES busy cycles, performs the array access, and returns extended
// load data. StallM holds the pipeline for the whole access.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    dmem_responder_if.slave request/response bundle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; illegal requests are rejected here
// BUSY  | wait-state countdown; the array access happens when cnt hits 0
// DONE  | result valid, StallM released, pipeline advances
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic              stallRaw;
  logic              errNext;
  logic              accessEn;
  logic              reqLegal;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [31:0]       memWord;
  logic [31:0]       shifted;
  logic [31:0]       loadData;
  logic [3:0]        byteEn;
  logic [31:0]       wdLanes;
  logic [31:0]       readData;
  logic              errQ;
  logic [31:0]       mem [DEPTH_WORDS];

  // Address bits above the word index alias onto the same array.
  logic unusedAddrHi;
  assign unusedAddrHi = ^bus.ALUResultM[31:IDX_W+2];

  assign idx  = bus.ALUResultM[2 +: IDX_W];
  assign lane = bus.ALUResultM[1:0];

  always_comb begin
    reqLegal = 1'b0;
    case (bus.funct3M)
      3'b000:  reqLegal = 1'b1;
      3'b001:  reqLegal = !lane[0];
      3'b010:  reqLegal = (lane == 2'b00);
      3'b100:  reqLegal = !bus.MemWriteM;
      3'b101:  reqLegal = !bus.MemWriteM && !lane[0];
      default: reqLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stallRaw  = 1'b0;
    errNext   = 1'b0;
    accessEn  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ReqValidM) begin
          if (reqLegal) begin
            stallRaw  = 1'b1;
            stateNext = BUSY;
            cntNext   = 4'(WAIT_CYCLES);
          end else begin
            errNext = 1'b1;
          end
        end
      end
      BUSY: begin
        stallRaw = 1'b1;
        if (cnt != 4'd0) begin
          cntNext = cnt - 4'd1;
        end else begin
          accessEn  = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        // Request still on the bus here is the one just completed.
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // A legal request in IDLE would otherwise raise StallM combinationally
  // while reset is held.
  assign bus.StallM = stallRaw & reset;

  always_comb begin
    byteEn  = 4'b1111;
    wdLanes = bus.WriteDataM;
    case (bus.funct3M)
      3'b000: begin
        byteEn  = 4'b0001 << lane;
        wdLanes = {4{bus.WriteDataM[7:0]}};
      end
      3'b001: begin
        byteEn  = lane[1] ? 4'b1100 : 4'b0011;
        wdLanes = {2{bus.WriteDataM[15:0]}};
      end
      default: begin
        byteEn  = 4'b1111;
        wdLanes = bus.WriteDataM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accessEn && bus.MemWriteM) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[idx][8*i +: 8] <= wdLanes[8*i +: 8];
      end
    end
  end

  assign memWord = mem[idx];
  assign shifted = memWord >> {lane, 3'b000};

  always_comb begin
    loadData = memWord;
    case (bus.funct3M)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  loadData = {24'd0, shifted[7:0]};
      3'b101:  loadData = {16'd0, shifted[15:0]};
      default: loadData = memWord;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readData <= 32'd0;
      errQ     <= 1'b0;
    end else begin
      errQ <= errNext;
      if (errNext) begin
        readData <= 32'd0;
      end else if (accessEn) begin
        readData <= bus.MemWriteM ? 32'd0 : loadData;
      end
    end
  end

  assign bus.ReadDataM = readData;
  assign bus.ErrM      = errQ;

endmodule
